// File: rtl/ysyx_22041412_mdu_ctrl.sv
// Issue/sequence controller for the shared iterative MUL/DIV unit.
// Resolves RISC-V divide special cases locally, stalls while the MDU runs, holds results for writeback.
module ysyx_22041412_mdu_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 80
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            Mul_en,
  input  logic            Div_en,
  input  logic [2:0]      func3,
  input  logic [1:0]      RV64_en,
  input  logic [4:0]      Rd,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  input  logic            wb_ready,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result,
  output logic            mdu_start,
  output logic [2:0]      mdu_op,
  output logic            mdu_word,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  output logic            mdu_kill,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_RESP = 2'd2} state_t;

  // Writeback handshake: a result transfers on any cycle where wb_valid & wb_ready.
  // wb_valid is forced low during flush so a same-cycle wb_ready never commits.
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              start_q, start_d, kill_q, kill_d, err_q, err_d, word_q, word_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;

  logic              md, is_w, div_zero, div_ovf, special;
  logic [XLEN-1:0]   dvd, dvs, min_neg, special_res;

  assign md   = issue_valid & (Mul_en | Div_en);
  assign is_w = (RV64_en == 2'b10);

  // W-forms judge only the low word, sign-extended, so both widths share one compare.
  assign dvd      = is_w ? {{(XLEN-32){src1[31]}}, src1[31:0]} : src1;
  assign dvs      = is_w ? {{(XLEN-32){src2[31]}}, src2[31:0]} : src2;
  assign min_neg  = is_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (dvs == '0);
  assign div_ovf  = ~func3[0] & (dvd == min_neg) & (dvs == '1);
  assign special  = Div_en & (div_zero | div_ovf);
  assign special_res = div_zero ? (func3[1] ? dvd : '1) : (func3[1] ? '0 : dvd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
      word_q  <= word_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    kill_d  = 1'b0;
    err_d   = err_q;
    word_d  = word_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && md) begin
          op_d   = func3;
          word_d = is_w;
          rd_d   = Rd;
          a_d    = src1;
          b_d    = src2;
          if (special) begin
            data_d  = special_res;
            state_d = S_RESP;
          end else begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          kill_d  = 1'b1;
          state_d = S_IDLE;
        end else if (mdu_done) begin
          data_d  = word_q ? {{(XLEN-32){mdu_result[31]}}, mdu_result[31:0]} : mdu_result;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          kill_d  = 1'b1;
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (flush || wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall     = ((state_q == S_IDLE) & md) | (state_q == S_RUN) |
                ((state_q == S_RESP) & (~wb_ready | flush));
    wb_valid  = (state_q == S_RESP) & ~flush;
    mdu_start = start_q;
    mdu_kill  = kill_q;
    mdu_op    = op_q;
    mdu_word  = word_q;
    mdu_a     = a_q;
    mdu_b     = b_q;
    wb_rd     = rd_q;
    wb_data   = data_q;
    err       = err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_ysyx_22041412_mdu_ctrl.sv
// Directed bench for the MDU issue controller: special-case divides, MUL/MULW sequencing,
// writeback backpressure, flush and timeout.
module tb_ysyx_22041412_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0, Mul_en = 1'b0, Div_en = 1'b0;
  logic [2:0]  func3 = '0;
  logic [1:0]  RV64_en = '0;
  logic [4:0]  Rd = '0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        flush = 1'b0, wb_ready = 1'b0, mdu_done = 1'b0;
  logic [63:0] mdu_result = '0;
  logic        mdu_start, mdu_word, mdu_kill, stall, wb_valid, err;
  logic [2:0]  mdu_op;
  logic [63:0] mdu_a, mdu_b, wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  ysyx_22041412_mdu_ctrl #(.XLEN(64), .TIMEOUT(80)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .Mul_en(Mul_en), .Div_en(Div_en),
    .func3(func3), .RV64_en(RV64_en), .Rd(Rd), .src1(src1), .src2(src2), .flush(flush),
    .wb_ready(wb_ready), .mdu_done(mdu_done), .mdu_result(mdu_result), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .mdu_word(mdu_word), .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_kill(mdu_kill),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle; stall must rise combinationally while it waits in IDLE.
  task automatic issue(input logic mul, input logic div, input logic [2:0] f3,
                       input logic [1:0] w, input logic [4:0] rd,
                       input logic [63:0] a, input logic [63:0] b);
    issue_valid = 1'b1; Mul_en = mul; Div_en = div; func3 = f3; RV64_en = w;
    Rd = rd; src1 = a; src2 = b;
    #1;
    chk("issue_stall", stall, 1'b1);
    tick();
    issue_valid = 1'b0; Mul_en = 1'b0; Div_en = 1'b0;
  endtask

  task automatic accept();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("accept_idle", dbg_state, 2'd0);
    chk("accept_wbv", wb_valid, 1'b0);
  endtask

  task automatic done_pulse(input logic [63:0] r);
    mdu_done = 1'b1; mdu_result = r;
    tick();
    mdu_done = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_start", mdu_start, 1'b0);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_data", wb_data, 64'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst_n = 1'b1;
    tick();

    // MUL 7 * -3 with done 5 cycles after start, then 3 cycles of backpressure
    issue(1'b1, 1'b0, 3'b000, 2'b00, 5'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_start", mdu_start, 1'b1);
    chk("mul_a", mdu_a, 64'd7);
    chk("mul_b", mdu_b, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_op", mdu_op, 3'b000);
    chk("mul_word", mdu_word, 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("mul_run_stall", stall, 1'b1);
      chk("mul_run_start", mdu_start, 1'b0);
      chk("mul_run_wbv", wb_valid, 1'b0);
    end
    tick();
    done_pulse(64'hFFFF_FFFF_FFFF_FFEB);
    for (int i = 0; i < 3; i++) begin
      chk("mul_hold_wbv", wb_valid, 1'b1);
      chk("mul_hold_data", wb_data, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("mul_hold_rd", wb_rd, 5'd5);
      chk("mul_hold_stall", stall, 1'b1);
      tick();
    end
    wb_ready = 1'b1; #1;
    chk("mul_ready_stall", stall, 1'b0);
    chk("mul_ready_wbv", wb_valid, 1'b1);
    wb_ready = 1'b0;
    accept();

    // DIV 20/0 resolves locally
    issue(1'b0, 1'b1, 3'b100, 2'b00, 5'd3, 64'd20, 64'd0);
    chk("div0_start", mdu_start, 1'b0);
    chk("div0_wbv", wb_valid, 1'b1);
    chk("div0_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("div0_rd", wb_rd, 5'd3);
    accept();

    // REMU 20/0 -> dividend
    issue(1'b0, 1'b1, 3'b111, 2'b00, 5'd4, 64'd20, 64'd0);
    chk("remu0_start", mdu_start, 1'b0);
    chk("remu0_data", wb_data, 64'd20);
    accept();

    // DIVW overflow
    issue(1'b0, 1'b1, 3'b100, 2'b10, 5'd6, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divw_ovf_start", mdu_start, 1'b0);
    chk("divw_ovf_wbv", wb_valid, 1'b1);
    chk("divw_ovf_data", wb_data, 64'hFFFF_FFFF_8000_0000);
    accept();

    // REMW overflow -> 0
    issue(1'b0, 1'b1, 3'b110, 2'b10, 5'd7, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("remw_ovf_start", mdu_start, 1'b0);
    chk("remw_ovf_data", wb_data, 64'd0);
    accept();

    // 64-bit DIV overflow -> dividend
    issue(1'b0, 1'b1, 3'b100, 2'b00, 5'd8, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("div_ovf_data", wb_data, 64'h8000_0000_0000_0000);
    accept();

    // DIVW whose low divisor word is zero is a divide-by-zero
    issue(1'b0, 1'b1, 3'b100, 2'b10, 5'd9, 64'd5, 64'h0000_0001_0000_0000);
    chk("divw0_start", mdu_start, 1'b0);
    chk("divw0_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    accept();

    // Unsigned DIVU with all-ones divisor is not special: goes to the MDU
    issue(1'b0, 1'b1, 3'b101, 2'b00, 5'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divu_start", mdu_start, 1'b1);
    chk("divu_state", dbg_state, 2'd1);
    done_pulse(64'd0);
    chk("divu_data", wb_data, 64'd0);
    chk("divu_rd0", wb_rd, 5'd0);
    accept();

    // MULW result is sign-extended from bit 31
    issue(1'b1, 1'b0, 3'b000, 2'b10, 5'd10, 64'd3, 64'd4);
    chk("mulw_start", mdu_start, 1'b1);
    chk("mulw_word", mdu_word, 1'b1);
    done_pulse(64'h0000_0001_8000_0000);
    chk("mulw_data", wb_data, 64'hFFFF_FFFF_8000_0000);
    accept();

    // Flush 2 cycles into RUN; late done ignored
    issue(1'b1, 1'b0, 3'b000, 2'b00, 5'd11, 64'd2, 64'd2);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_run_kill", mdu_kill, 1'b1);
    chk("fl_run_state", dbg_state, 2'd0);
    chk("fl_run_wbv", wb_valid, 1'b0);
    done_pulse(64'd99);
    chk("fl_run_kill_once", mdu_kill, 1'b0);
    chk("fl_late_done_state", dbg_state, 2'd0);
    chk("fl_late_done_wbv", wb_valid, 1'b0);

    // Flush in IDLE blocks issue
    flush = 1'b1;
    issue(1'b1, 1'b0, 3'b000, 2'b00, 5'd12, 64'd1, 64'd1);
    flush = 1'b0;
    chk("fl_idle_state", dbg_state, 2'd0);
    chk("fl_idle_start", mdu_start, 1'b0);

    // Flush in RESP with wb_ready high: no writeback
    issue(1'b0, 1'b1, 3'b100, 2'b00, 5'd13, 64'd1, 64'd0);
    flush = 1'b1; wb_ready = 1'b1; #1;
    chk("fl_resp_wbv", wb_valid, 1'b0);
    chk("fl_resp_stall", stall, 1'b1);
    tick();
    flush = 1'b0; wb_ready = 1'b0;
    chk("fl_resp_state", dbg_state, 2'd0);

    // Hung MDU: kill after TIMEOUT run cycles
    issue(1'b1, 1'b0, 3'b001, 2'b00, 5'd14, 64'd9, 64'd9);
    chk("to_start", mdu_start, 1'b1);
    n = 0;
    while (!mdu_kill && n < 200) begin
      tick();
      n++;
    end
    chk("to_cycles", 64'(n), 64'd80);
    chk("to_kill", mdu_kill, 1'b1);
    chk("to_err", err, 1'b1);
    chk("to_wbv", wb_valid, 1'b1);
    chk("to_data", wb_data, 64'd0);
    chk("to_rd", wb_rd, 5'd14);
    accept();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("to_err_sticky", err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
